ssd_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a bank of common-anode 7-segment displays that share one segment bus.
- Sequences DIGITS hex nibbles through a single internal hex-to-7-segment decoder, driving one anode at a time.
- Inserts a blanking gap between digits to prevent ghosting.
- Accepts new display values through a load handshake. Values are committed only at frame boundaries, so a frame never shows a torn value.
- Sits between the switch/datapath logic and the board's SSD and anode pins.

---
 rtl/ssd_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment digits
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   enable          scan enable, low keeps the display dark
//   value, load     hex nibbles (digit 0 rightmost) and one-cycle capture request
//   pending         captured value waiting for the next frame boundary
//   SSD, AN         active-low segments (SSD[0]=a) and active-low anodes
//   frame_tick      one-cycle pulse on the last cycle of each frame
// Optional: define SSD_LZ_BLANK_EN for leading-zero blanking.
module ssd_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    output logic                  pending,
    output logic [6:0]            SSD,
    output logic [DIGITS-1:0]     AN,
    output logic                  frame_tick
);
    localparam int CW = $clog2(PRESCALE);
    localparam int DW = $clog2(DIGITS);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         digit_q, digit_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d, disp_q, disp_d;
    logic                  pending_q, pending_d, tick_q, tick_d;
    logic [6:0]            ssd_q, ssd_d;
    logic [DIGITS-1:0]     an_q, an_d, vis;
    logic                  run, last_cnt, commit_win, show, nz;
    logic [3:0]            nib;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h40;
            4'h1: seg_of = 7'h79;
            4'h2: seg_of = 7'h24;
            4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;
            4'h5: seg_of = 7'h12;
            4'h6: seg_of = 7'h02;
            4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;
            4'h9: seg_of = 7'h18;
            4'hA: seg_of = 7'h20;
            4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46;
            4'hD: seg_of = 7'h21;
            4'hE: seg_of = 7'h06;
            default: seg_of = 7'h0E;
        endcase
    endfunction

    always_comb begin
        run      = state_q == SCAN && enable;
        last_cnt = cnt_q == CW'(PRESCALE - 1);
        state_d  = enable ? SCAN : IDLE;
        cnt_d    = run && !last_cnt ? cnt_q + CW'(1) : '0;
        digit_d  = !run ? '0 :
                   !last_cnt ? digit_q :
                   digit_q == DW'(DIGITS - 1) ? '0 : digit_q + DW'(1);
        // A commit slot is the frame's last cycle while scanning, or any cycle in IDLE
        // with something pending; a load landing in that slot bypasses straight to disp.
        commit_win = state_q == SCAN ? tick_q : pending_q;
        shadow_d   = load ? value : shadow_q;
        disp_d     = !commit_win ? disp_q : load ? value : pending_q ? shadow_q : disp_q;
        pending_d  = !commit_win && (pending_q || load);
        tick_d     = state_d == SCAN && cnt_d == CW'(PRESCALE - 1) && digit_d == DW'(DIGITS - 1);
        show       = state_d == SCAN && cnt_d >= CW'(BLANK_CYC);
        nib        = disp_d[{digit_d, 2'b00} +: 4];
`ifdef SSD_LZ_BLANK_EN
        // Walk down from the top nibble; a digit is visible once any nibble at or
        // above it is nonzero, and digit 0 is always visible.
        nz  = 1'b0;
        vis = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz     = nz | (|disp_d[4*i +: 4]);
            vis[i] = nz || i == 0;
        end
`else
        nz  = 1'b0;
        vis = '1;
`endif
        ssd_d = show && vis[digit_d] ? seg_of(nib) : 7'h7F;
        for (int i = 0; i < DIGITS; i++)
            an_d[i] = !(show && digit_d == DW'(i));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            digit_q   <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            ssd_q     <= 7'h7F;
            an_q      <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            ssd_q     <= ssd_d;
            an_q      <= an_d;
        end
    end

    assign pending    = pending_q;
    assign SSD        = ssd_q;
    assign AN         = an_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed self-checking bench for ssd_scan_ctrl (4 digits, 8-cycle slots)
module tb_ssd_scan_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        pending, frame_tick;
    logic [6:0]  SSD;
    logic [3:0]  AN;

    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];

    ssd_scan_ctrl #(.DIGITS(4), .PRESCALE(8), .BLANK_CYC(2)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .value(value), .load(load),
        .pending(pending), .SSD(SSD), .AN(AN), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h20, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [15:0] v);
        logic vis;
        for (int d = 0; d < 4; d++) begin
`ifdef SSD_LZ_BLANK_EN
            vis = d == 0 || (v >> (4*d)) != 0;
`else
            vis = 1'b1;
`endif
            exp_q.push_back({4'b1111 ^ (4'b0001 << d), vis ? seg_ref(v[4*d +: 4]) : 7'h7F});
        end
    endtask

    task automatic run_frame();
        logic [10:0] e = '0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("pending_after_commit", pending, 0);
                load = 1'b0;
            end
            if (k % 8 < 2) begin
                chk("blank_an", AN, 4'hF);
                chk("blank_ssd", SSD, 7'h7F);
            end else begin
                if (k % 8 == 2) begin
                    if (exp_q.size() == 0) chk("queue_empty", 1, 0);
                    else e = exp_q.pop_front();
                end
                chk("show_an", AN, e[10:7]);
                chk("show_ssd", SSD, e[6:0]);
            end
            chk("frame_tick", frame_tick, k == 31);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 64);
        chk("tick_seen", frame_tick, 1);
    endtask

    initial begin
        #23;
        chk("rst_ssd", SSD, 7'h7F);
        chk("rst_an", AN, 4'hF);
        chk("rst_pending", pending, 0);
        chk("rst_tick", frame_tick, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_ssd", SSD, 7'h7F);
            chk("idle_an", AN, 4'hF);
            chk("idle_pending", pending, 0);
        end
        enable = 1'b1;
        load = 1'b1;
        value = 16'h3A0F;
        @(negedge clk);
        load = 1'b0;
        chk("pending_set", pending, 1);
        wait_tick();
        chk("pending_at_tick", pending, 1);
        push_frame(16'h3A0F);
        run_frame();
        repeat (3) @(negedge clk);
        load = 1'b1;
        value = 16'h1111;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        load = 1'b1;
        value = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        chk("pending_mid", pending, 1);
        wait_tick();
        chk("pending_hold", pending, 1);
        push_frame(16'h2222);
        run_frame();
        load = 1'b1;
        value = 16'h0009;
        push_frame(16'h0009);
        run_frame();
        repeat (22) @(negedge clk);
        chk("pre_drop_an", AN, 4'b1011);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_an", AN, 4'hF);
        chk("drop_ssd", SSD, 7'h7F);
        chk("drop_tick", frame_tick, 0);
        repeat (2) @(negedge clk);
        chk("dark_an", AN, 4'hF);
        enable = 1'b1;
        push_frame(16'h0009);
        run_frame();
        @(negedge clk);
        load = 1'b1;
        value = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk("pending_before_rst", pending, 1);
        repeat (2) @(negedge clk);
        chk("pre_rst_an", AN, 4'b1110);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ssd", SSD, 7'h7F);
        chk("arst_an", AN, 4'hF);
        chk("arst_pending", pending, 0);
        chk("arst_tick", frame_tick, 0);
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        load = 1'b1;
        value = 16'h0005;
        @(negedge clk);
        load = 1'b0;
        chk("idle_pending_set", pending, 1);
        @(negedge clk);
        chk("idle_commit", pending, 0);
        enable = 1'b1;
        push_frame(16'h0005);
        run_frame();
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
